// File: rtl/matrix_multiplier_seq.sv
`default_nettype none
// =============================================================================
// Module   : matrix_multiplier_seq
// Brief    : Sequential C = A x B using one row of B_COLUMNS MAC units, with
//            valid/ready handshakes on both sides. Optional cross-transaction
//            accumulation is enabled by MATRIX_MULTIPLIER_SEQ_ACCUMULATE_EN.
// Revision : 1.0 - initial release
// =============================================================================
module matrix_multiplier_seq #(
    parameter int DATA_WIDTH       = 8,
    parameter int A_ROWS           = 8,
    parameter int B_COLUMNS        = 5,
    parameter int A_COLUMNS_B_ROWS = 4,
    parameter int IS_SIGNED        = 0,
    parameter int C_DATA_WIDTH     = (2*DATA_WIDTH)+$clog2(A_COLUMNS_B_ROWS)
) (
    input  logic                                              clk_i,
    input  logic                                              reset_ni,
    input  logic                                              valid_i,
    output logic                                              ready_o,
    input  logic                                              accumulate_i,
    input  logic [A_ROWS*A_COLUMNS_B_ROWS*DATA_WIDTH-1:0]     a_i,
    input  logic [A_COLUMNS_B_ROWS*B_COLUMNS*DATA_WIDTH-1:0]  b_i,
    output logic                                              valid_o,
    input  logic                                              ready_i,
    output logic                                              busy_o,
    output logic [A_ROWS*B_COLUMNS*C_DATA_WIDTH-1:0]          c_o
);

    localparam int K     = A_COLUMNS_B_ROWS;
    localparam int CW    = C_DATA_WIDTH;
    localparam int EXT_W = CW - DATA_WIDTH;
    localparam int I_W   = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
    localparam int K_W   = (K > 1) ? $clog2(K) : 1;

    localparam logic [I_W-1:0] I_LAST = I_W'(A_ROWS - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(K - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  busy_q,  busy_d;
    logic [I_W-1:0]        i_q, i_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [DATA_WIDTH-1:0] a_q   [A_ROWS][K];
    logic [DATA_WIDTH-1:0] a_d   [A_ROWS][K];
    logic [DATA_WIDTH-1:0] b_q   [K][B_COLUMNS];
    logic [DATA_WIDTH-1:0] b_d   [K][B_COLUMNS];
    logic [CW-1:0]         acc_q [A_ROWS][B_COLUMNS];
    logic [CW-1:0]         acc_d [A_ROWS][B_COLUMNS];

    logic w_accept;
    logic w_last_step;
    logic w_clear;

`ifdef MATRIX_MULTIPLIER_SEQ_ACCUMULATE_EN
    assign w_clear = !accumulate_i;
`else
    logic w_unused_accumulate;
    assign w_unused_accumulate = accumulate_i;
    assign w_clear             = 1'b1;
`endif

    assign w_accept    = (state_q == S_IDLE) && valid_i && ready_q;
    assign w_last_step = (state_q == S_COMPUTE) && (i_q == I_LAST) && (k_q == K_LAST);

    // Operands are widened to the result width first so the wrap is modulo 2^CW.
    function automatic logic [CW-1:0] extend(input logic [DATA_WIDTH-1:0] v);
        if (IS_SIGNED != 0) begin
            extend = {{EXT_W{v[DATA_WIDTH-1]}}, v};
        end else begin
            extend = {{EXT_W{1'b0}}, v};
        end
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (w_accept)          state_d = S_COMPUTE;
            S_COMPUTE: if (w_last_step)       state_d = S_DONE;
            S_DONE:    if (valid_q && ready_i) state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // ready waits one extra cycle in IDLE so it never overlaps valid on release.
    always_comb begin
        ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d == S_COMPUTE);
    end

    // ---------------- Datapath ----------------
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        i_d   = i_q;
        k_d   = k_q;
        if (w_accept) begin
            for (int r = 0; r < A_ROWS; r++) begin
                for (int kk = 0; kk < K; kk++) begin
                    a_d[r][kk] = a_i[(r*K + kk)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int kk = 0; kk < K; kk++) begin
                for (int j = 0; j < B_COLUMNS; j++) begin
                    b_d[kk][j] = b_i[(kk*B_COLUMNS + j)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (w_clear) begin
                for (int r = 0; r < A_ROWS; r++) begin
                    for (int j = 0; j < B_COLUMNS; j++) begin
                        acc_d[r][j] = '0;
                    end
                end
            end
            i_d = '0;
            k_d = '0;
        end else if (state_q == S_COMPUTE) begin
            for (int j = 0; j < B_COLUMNS; j++) begin
                acc_d[i_q][j] = acc_q[i_q][j]
                              + extend(a_q[i_q][k_q]) * extend(b_q[k_q][j]);
            end
            if (k_q == K_LAST) begin
                k_d = '0;
                i_d = (i_q == I_LAST) ? '0 : i_q + I_W'(1);
            end else begin
                k_d = k_q + K_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            i_q <= '0;
            k_q <= '0;
            for (int r = 0; r < A_ROWS; r++) begin
                for (int kk = 0; kk < K; kk++) begin
                    a_q[r][kk] <= '0;
                end
                for (int j = 0; j < B_COLUMNS; j++) begin
                    acc_q[r][j] <= '0;
                end
            end
            for (int kk = 0; kk < K; kk++) begin
                for (int j = 0; j < B_COLUMNS; j++) begin
                    b_q[kk][j] <= '0;
                end
            end
        end else begin
            i_q   <= i_d;
            k_q   <= k_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

    generate
        for (genvar r = 0; r < A_ROWS; r++) begin : g_row
            for (genvar j = 0; j < B_COLUMNS; j++) begin : g_col
                assign c_o[(r*B_COLUMNS + j)*CW +: CW] = acc_q[r][j];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_matrix_multiplier_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_matrix_multiplier_seq
// Brief    : Self-checking bench for matrix_multiplier_seq (unsigned and signed
//            instances) against a transaction-level matrix model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_matrix_multiplier_seq;

    localparam int DW  = 8;
    localparam int AR  = 8;
    localparam int BC  = 5;
    localparam int K   = 4;
    localparam int CW  = 2*DW + $clog2(K);
    localparam int LAT = AR*K;
    localparam int NA  = AR*K;
    localparam int NB  = K*BC;
    localparam int NC  = AR*BC;
    localparam longint MASK = (longint'(1) << CW) - 1;
`ifdef MATRIX_MULTIPLIER_SEQ_ACCUMULATE_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
    logic valid_i = 1'b0;
    logic accumulate_i = 1'b0;
    logic ready_i = 1'b0;
    logic [NA*DW-1:0] a_i = '0;
    logic [NB*DW-1:0] b_i = '0;
    logic ready_u, valid_u, busy_u, ready_s, valid_s, busy_s;
    logic [NC*CW-1:0] c_u, c_s;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bit     m_ready, m_valid, m_busy;
    int     m_cnt;
    longint m_cu [NC];
    longint m_cs [NC];
    longint p_cu [NC];
    longint p_cs [NC];

    always #5 clk_i = ~clk_i;

    matrix_multiplier_seq #(.DATA_WIDTH(DW), .A_ROWS(AR), .B_COLUMNS(BC),
        .A_COLUMNS_B_ROWS(K), .IS_SIGNED(0)) u_dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_u),
        .accumulate_i(accumulate_i), .a_i(a_i), .b_i(b_i), .valid_o(valid_u),
        .ready_i(ready_i), .busy_o(busy_u), .c_o(c_u));

    matrix_multiplier_seq #(.DATA_WIDTH(DW), .A_ROWS(AR), .B_COLUMNS(BC),
        .A_COLUMNS_B_ROWS(K), .IS_SIGNED(1)) u_dut_s (
        .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_s),
        .accumulate_i(accumulate_i), .a_i(a_i), .b_i(b_i), .valid_o(valid_s),
        .ready_i(ready_i), .busy_o(busy_s), .c_o(c_s));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_c(input string nm, input logic [NC*CW-1:0] act, input bit sgn);
        int     bad;
        longint ex;
        bad = -1;
        for (int e = 0; e < NC; e++) begin
            ex = sgn ? m_cs[e] : m_cu[e];
            if (longint'(act[e*CW +: CW]) != ex && bad < 0) bad = e;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            ex = sgn ? m_cs[bad] : m_cu[bad];
            $display("FAIL %s elem %0d: got %0h expected %0h at %0t",
                     nm, bad, act[bad*CW +: CW], ex, $time);
        end
    endtask

    function automatic longint sx(input logic [DW-1:0] v);
        return v[DW-1] ? longint'(v) - (longint'(1) << DW) : longint'(v);
    endfunction

    // Plain matrix product of the operands presented on the accept edge.
    task automatic model_product(input bit acc);
        longint su, ss, ua, ub;
        for (int i = 0; i < AR; i++) begin
            for (int j = 0; j < BC; j++) begin
                su = 0;
                ss = 0;
                for (int k = 0; k < K; k++) begin
                    ua = longint'(a_i[(i*K + k)*DW +: DW]);
                    ub = longint'(b_i[(k*BC + j)*DW +: DW]);
                    su += ua * ub;
                    ss += sx(a_i[(i*K + k)*DW +: DW]) * sx(b_i[(k*BC + j)*DW +: DW]);
                end
                if (ACC_ON && acc) begin
                    su += m_cu[i*BC + j];
                    ss += m_cs[i*BC + j];
                end
                p_cu[i*BC + j] = su & MASK;
                p_cs[i*BC + j] = ss & MASK;
            end
        end
    endtask

    // Transaction timeline: idle/ready, LAT cycles computing, done until taken.
    always @(posedge clk_i) begin
        if (!reset_ni) begin
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_cnt   = 0;
            for (int e = 0; e < NC; e++) begin
                m_cu[e] = 0;
                m_cs[e] = 0;
            end
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
                m_cu    = p_cu;
                m_cs    = p_cs;
            end
        end else if (m_valid) begin
            if (ready_i) m_valid = 1'b0;
        end else if (m_ready) begin
            if (valid_i) begin
                m_ready = 1'b0;
                m_busy  = 1'b1;
                m_cnt   = LAT;
                model_product(accumulate_i);
            end
        end else begin
            m_ready = 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("ready_u", ready_u, m_ready);
            chk("valid_u", valid_u, m_valid);
            chk("busy_u",  busy_u,  m_busy);
            chk("ready_s", ready_s, m_ready);
            chk("valid_s", valid_s, m_valid);
            chk("busy_s",  busy_s,  m_busy);
            chk("ready_valid_excl", ready_u && valid_u, 0);
            if (!m_busy) begin
                cmp_c("c_u", c_u, 1'b0);
                cmp_c("c_s", c_s, 1'b1);
            end
        end
    end

    task automatic fill(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int e = 0; e < NA; e++) a_i[e*DW +: DW] = av;
        for (int e = 0; e < NB; e++) b_i[e*DW +: DW] = bv;
    endtask

    task automatic randomize_ops();
        for (int e = 0; e < NA; e++) a_i[e*DW +: DW] = DW'($urandom);
        for (int e = 0; e < NB; e++) b_i[e*DW +: DW] = DW'($urandom);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready_u !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("accept_ready", ready_u, 1);
    endtask

    task automatic run_txn(input bit acc, input int hold, output int lat);
        wait_ready();
        valid_i = 1'b1;
        accumulate_i = acc;
        @(negedge clk_i);
        valid_i = 1'b0;
        accumulate_i = 1'b0;
        randomize_ops();
        lat = 0;
        while (valid_u !== 1'b1 && lat < 200) begin
            ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            lat++;
        end
        chk("valid_seen", valid_u, 1);
        for (int h = 0; h < hold; h++) begin
            ready_i = 1'b0;
            valid_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            chk("bp_ready_low", ready_u, 0);
            chk("bp_valid_held", valid_u, 1);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        chk("hs_valid_fall", valid_u, 0);
        chk("hs_ready_low", ready_u, 0);
        @(negedge clk_i);
        chk("hs_ready_rise", ready_u, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        longint ex;

        @(posedge clk_i);
        chk_en = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("rst_ready", ready_u, 0);
        chk("rst_valid", valid_u, 0);
        chk("rst_c0", longint'(c_u[0 +: CW]), 0);
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_release_ready", ready_u, 1);

        // Unsigned maximum
        fill(8'hFF, 8'hFF);
        run_txn(1'b0, 0, lat);
        chk("max_latency", lat, 32);
        chk("max_c_first", longint'(c_u[0 +: CW]), 'h3F804);
        chk("max_c_last", longint'(c_u[(NC-1)*CW +: CW]), 'h3F804);
        chk("model_max", m_cu[NC-1], 'h3F804);
        chk("max_signed", longint'(c_s[0 +: CW]), 4);

        // Accumulate on top of the previous result
        fill(8'hFF, 8'hFF);
        run_txn(1'b1, 0, lat);
        chk("acc_c_first", longint'(c_u[0 +: CW]), ACC_ON ? 'h3F008 : 'h3F804);
        chk("model_acc", m_cu[7], ACC_ON ? 'h3F008 : 'h3F804);

        // Identity rows with backpressure and stray valid pulses
        for (int i = 0; i < AR; i++)
            for (int k = 0; k < K; k++)
                a_i[(i*K + k)*DW +: DW] = (i == k) ? DW'(1) : DW'(0);
        for (int k = 0; k < K; k++)
            for (int j = 0; j < BC; j++)
                b_i[(k*BC + j)*DW +: DW] = DW'(k*5 + j + 1);
        run_txn(1'b0, 10, lat);
        bad = 0;
        for (int i = 0; i < AR; i++) begin
            for (int j = 0; j < BC; j++) begin
                ex = (i < K) ? longint'(i*5 + j + 1) : 0;
                if (longint'(c_u[(i*BC + j)*CW +: CW]) != ex) bad++;
            end
        end
        chk("identity_bad_elems", bad, 0);
        chk("identity_c23", longint'(c_u[(2*BC + 3)*CW +: CW]), 14);

        // Signed
        fill(8'h80, 8'h80);
        run_txn(1'b0, 1, lat);
        chk("signed_80", longint'(c_s[0 +: CW]), 'h10000);
        chk("model_signed_80", m_cs[NC-1], 'h10000);
        fill(8'hFF, 8'h01);
        run_txn(1'b0, 2, lat);
        chk("signed_m4", longint'(c_s[0 +: CW]), 'h3FFFC);
        chk("model_signed_m4", m_cs[3], 'h3FFFC);
        chk("unsigned_ff01", longint'(c_u[0 +: CW]), 1020);

        // Random transactions
        for (int t = 0; t < 10; t++) begin
            randomize_ops();
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 4), lat);
            chk("rand_latency", lat, LAT);
        end

        // Reset in the middle of COMPUTE
        fill(8'h11, 8'h22);
        wait_ready();
        valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        reset_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("midrst_c0", longint'(c_u[0 +: CW]), 0);
        chk("midrst_valid", valid_u, 0);
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_ready", ready_u, 1);

        // Accumulate after reset starts from zero
        fill(8'hFF, 8'hFF);
        run_txn(1'b1, 0, lat);
        chk("post_rst_acc", longint'(c_u[0 +: CW]), 'h3F804);

        repeat (3) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
